// File: rtl/csi2tx_dphy_clk_lane_seq_if.sv
// Clock-lane sequencer interface: lane-management requests and timing in, clock-lane LP/HS controls out.
interface csi2tx_dphy_clk_lane_seq_if #(
    parameter int unsigned NUM_DLANES = 4,
    parameter int unsigned CNT_W      = 8
);
    logic                  txrequesths_clk;
    logic                  cont_clk_mode;
    logic [NUM_DLANES-1:0] dlane_en;
    logic [NUM_DLANES-1:0] eot;
    logic                  txulpsclk;
    logic                  txulpsexit_clk;
    logic [CNT_W-1:0]      cln_cnt_lpx;
    logic [CNT_W-1:0]      cln_cnt_hs_prep;
    logic [CNT_W-1:0]      cln_cnt_hs_zero;
    logic [CNT_W-1:0]      cln_cnt_hs_post;
    logic [CNT_W-1:0]      cln_cnt_hs_trail;
    logic [CNT_W-1:0]      cln_cnt_hs_exit;
    logic                  lp_tx_cntrl_clk;
    logic                  lp_tx_cp_clk;
    logic                  lp_tx_cn_clk;
    logic                  hs_tx_cntrl_clk;
    logic                  hs_clk_en;
    logic                  sot;
    logic                  stopstate_clk;
    logic                  ulpsactivenot_clk;

    modport master (
        output txrequesths_clk, cont_clk_mode, dlane_en, eot, txulpsclk, txulpsexit_clk,
        output cln_cnt_lpx, cln_cnt_hs_prep, cln_cnt_hs_zero, cln_cnt_hs_post,
        output cln_cnt_hs_trail, cln_cnt_hs_exit,
        input  lp_tx_cntrl_clk, lp_tx_cp_clk, lp_tx_cn_clk, hs_tx_cntrl_clk, hs_clk_en,
        input  sot, stopstate_clk, ulpsactivenot_clk
    );

    modport slave (
        input  txrequesths_clk, cont_clk_mode, dlane_en, eot, txulpsclk, txulpsexit_clk,
        input  cln_cnt_lpx, cln_cnt_hs_prep, cln_cnt_hs_zero, cln_cnt_hs_post,
        input  cln_cnt_hs_trail, cln_cnt_hs_exit,
        output lp_tx_cntrl_clk, lp_tx_cp_clk, lp_tx_cn_clk, hs_tx_cntrl_clk, hs_clk_en,
        output sot, stopstate_clk, ulpsactivenot_clk
    );
endinterface

// File: rtl/csi2tx_dphy_clk_lane_seq.sv
// D-PHY clock-lane TX sequencer: HS entry/burst/exit with EoT-gated exit and continuous-clock mode.
// Optional ULPS entry/exit states are built only when CSI2TX_DPHY_CLK_ULPS_EN is defined.
module csi2tx_dphy_clk_lane_seq #(
    parameter int unsigned NUM_DLANES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input logic                        txclkesc,
    input logic                        txescclk_rst,
    csi2tx_dphy_clk_lane_seq_if.slave  lane
);
    typedef enum logic [3:0] {
        ST_STOP, ST_HS_RQST, ST_HS_PREP, ST_HS_ZERO, ST_HS_CLK, ST_HS_POST, ST_HS_TRAIL, ST_HS_EXIT
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
        , ST_ULPS_RQST, ST_ULPS, ST_ULPS_EXIT
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DLANES-1:0] flags_q, flags_d;
    logic [NUM_DLANES-1:0] en_q, en_d;
    logic                  pend_q, pend_d;
    logic                  lp_cntrl_q, lp_cntrl_d, cp_q, cp_d, cn_q, cn_d;
    logic                  hs_cntrl_q, hs_cntrl_d, hs_clk_en_q, hs_clk_en_d;
    logic                  sot_q, sot_d, stop_q, stop_d, ulpsn_q, ulpsn_d;
    logic                  timer_done;
    logic                  all_eot;

    // A programmed duration of 0 still occupies one cycle.
    function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    assign timer_done = (cnt_q == '0);
    assign all_eot    = &(flags_q | lane.eot | ~en_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        en_d        = en_q;
        pend_d      = pend_q;
        lp_cntrl_d  = 1'b1;
        cp_d        = 1'b1;
        cn_d        = 1'b1;
        hs_cntrl_d  = 1'b0;
        hs_clk_en_d = 1'b0;
        sot_d       = 1'b0;
        stop_d      = 1'b0;
        ulpsn_d     = 1'b1;

        case (state_q)
            ST_STOP: begin
                if (lane.txrequesths_clk || pend_q) state_d = ST_HS_RQST;
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
                else if (lane.txulpsclk)          state_d = ST_ULPS_RQST;
`endif
            end
            ST_HS_RQST:  if (timer_done) state_d = ST_HS_PREP;
            ST_HS_PREP:  if (timer_done) state_d = ST_HS_ZERO;
            ST_HS_ZERO:  if (timer_done) state_d = ST_HS_CLK;
            ST_HS_CLK: begin
                flags_d = flags_q | lane.eot;
                if (!lane.txrequesths_clk && (lane.cont_clk_mode || all_eot)) state_d = ST_HS_POST;
            end
            ST_HS_POST:  if (timer_done) state_d = ST_HS_TRAIL;
            ST_HS_TRAIL: if (timer_done) state_d = ST_HS_EXIT;
            ST_HS_EXIT: begin
                if (lane.txrequesths_clk) pend_d = 1'b1;
                if (timer_done)           state_d = ST_STOP;
            end
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
            ST_ULPS_RQST: if (timer_done) state_d = ST_ULPS;
            ST_ULPS:      if (lane.txulpsexit_clk) state_d = ST_ULPS_EXIT;
            ST_ULPS_EXIT: if (timer_done && !lane.txulpsexit_clk) state_d = ST_STOP;
`endif
            default:     state_d = ST_STOP;
        endcase

        // Load the duration of the state being entered; otherwise count down to zero.
        if (state_d != state_q) begin
            case (state_d)
                ST_HS_RQST:   cnt_d = dur_m1(lane.cln_cnt_lpx);
                ST_HS_PREP:   cnt_d = dur_m1(lane.cln_cnt_hs_prep);
                ST_HS_ZERO:   cnt_d = dur_m1(lane.cln_cnt_hs_zero);
                ST_HS_POST:   cnt_d = dur_m1(lane.cln_cnt_hs_post);
                ST_HS_TRAIL:  cnt_d = dur_m1(lane.cln_cnt_hs_trail);
                ST_HS_EXIT:   cnt_d = dur_m1(lane.cln_cnt_hs_exit);
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
                ST_ULPS_RQST: cnt_d = dur_m1(lane.cln_cnt_lpx);
                ST_ULPS_EXIT: cnt_d = dur_m1(lane.cln_cnt_lpx);
`endif
                default:      cnt_d = '0;
            endcase
        end else if (!timer_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_d == ST_HS_CLK && state_q != ST_HS_CLK) begin
            flags_d = '0;
            en_d    = lane.dlane_en;
            sot_d   = 1'b1;
        end
        if (state_d == ST_HS_RQST) pend_d = 1'b0;

        // Outputs follow the state being entered so they change together with it.
        case (state_d)
            ST_STOP:     stop_d = 1'b1;
            ST_HS_RQST:  cp_d   = 1'b0;
            ST_HS_PREP:  begin cp_d = 1'b0; cn_d = 1'b0; end
            ST_HS_ZERO, ST_HS_TRAIL: begin
                lp_cntrl_d = 1'b0; cp_d = 1'b0; cn_d = 1'b0; hs_cntrl_d = 1'b1;
            end
            ST_HS_CLK, ST_HS_POST: begin
                lp_cntrl_d = 1'b0; cp_d = 1'b0; cn_d = 1'b0; hs_cntrl_d = 1'b1; hs_clk_en_d = 1'b1;
            end
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
            ST_ULPS_RQST, ST_ULPS_EXIT: cn_d = 1'b0;
            ST_ULPS:     begin cp_d = 1'b0; cn_d = 1'b0; ulpsn_d = 1'b0; end
`endif
            default:     ;
        endcase
    end

    always_ff @(posedge txclkesc) begin
        if (txescclk_rst) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            flags_q     <= '0;
            en_q        <= '0;
            pend_q      <= 1'b0;
            lp_cntrl_q  <= 1'b1;
            cp_q        <= 1'b1;
            cn_q        <= 1'b1;
            hs_cntrl_q  <= 1'b0;
            hs_clk_en_q <= 1'b0;
            sot_q       <= 1'b0;
            stop_q      <= 1'b1;
            ulpsn_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            lp_cntrl_q  <= lp_cntrl_d;
            cp_q        <= cp_d;
            cn_q        <= cn_d;
            hs_cntrl_q  <= hs_cntrl_d;
            hs_clk_en_q <= hs_clk_en_d;
            sot_q       <= sot_d;
            stop_q      <= stop_d;
            ulpsn_q     <= ulpsn_d;
        end
    end

`ifndef CSI2TX_DPHY_CLK_ULPS_EN
    logic unused_ulps;
    assign unused_ulps = ^{lane.txulpsclk, lane.txulpsexit_clk};
`endif

    assign lane.lp_tx_cntrl_clk   = lp_cntrl_q;
    assign lane.lp_tx_cp_clk      = cp_q;
    assign lane.lp_tx_cn_clk      = cn_q;
    assign lane.hs_tx_cntrl_clk   = hs_cntrl_q;
    assign lane.hs_clk_en         = hs_clk_en_q;
    assign lane.sot               = sot_q;
    assign lane.stopstate_clk     = stop_q;
    assign lane.ulpsactivenot_clk = ulpsn_q;
endmodule

// File: tb/tb_csi2tx_dphy_clk_lane_seq.sv
// Self-checking bench for csi2tx_dphy_clk_lane_seq: expected outputs come from per-state output
// tables and burst timelines computed arithmetically from programmed durations and EoT arrival times.
module tb_csi2tx_dphy_clk_lane_seq;
    localparam int unsigned NL = 4;
    localparam int unsigned CW = 8;

    localparam int P_STOP = 0, P_RQST = 1, P_PREP = 2, P_ZERO = 3, P_CLK = 4, P_POST = 5,
                   P_TRAIL = 6, P_EXIT = 7, P_ULRQ = 8, P_ULPS = 9, P_ULEX = 10;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   eot_t [NL];

    csi2tx_dphy_clk_lane_seq_if #(.NUM_DLANES(NL), .CNT_W(CW)) lane_if ();

    csi2tx_dphy_clk_lane_seq #(.NUM_DLANES(NL), .CNT_W(CW)) dut (
        .txclkesc     (clk),
        .txescclk_rst (rst),
        .lane         (lane_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: lp_cntrl, Cp, Cn, hs_cntrl, hs_clk_en, sot, stopstate, ulpsactivenot
    function automatic logic [7:0] exp_out(input int p, input bit s);
        case (p)
            P_STOP:  return 8'b1110_0011;
            P_RQST:  return 8'b1010_0001;
            P_PREP:  return 8'b1000_0001;
            P_ZERO:  return 8'b0001_0001;
            P_CLK:   return {7'b0001_100, 1'b0} | {5'b0, s, 2'b01};
            P_POST:  return 8'b0001_1001;
            P_TRAIL: return 8'b0001_0001;
            P_EXIT:  return 8'b1110_0001;
            P_ULRQ:  return 8'b1100_0001;
            P_ULPS:  return 8'b1000_0000;
            P_ULEX:  return 8'b1100_0001;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [7:0] obs();
        return {lane_if.lp_tx_cntrl_clk, lane_if.lp_tx_cp_clk, lane_if.lp_tx_cn_clk,
                lane_if.hs_tx_cntrl_clk, lane_if.hs_clk_en, lane_if.sot,
                lane_if.stopstate_clk, lane_if.ulpsactivenot_clk};
    endfunction

    function automatic int dur(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int lpx, input int prep, input int zero,
                              input int post, input int trail, input int ex);
        lane_if.cln_cnt_lpx      = CW'(lpx);
        lane_if.cln_cnt_hs_prep  = CW'(prep);
        lane_if.cln_cnt_hs_zero  = CW'(zero);
        lane_if.cln_cnt_hs_post  = CW'(post);
        lane_if.cln_cnt_hs_trail = CW'(trail);
        lane_if.cln_cnt_hs_exit  = CW'(ex);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_STOP, 0)) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=%b", got, exp_out(P_STOP, 0));
        end
        rst = 1'b0;
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_STOP, 0)) begin
            n_fail++;
            $display("FAIL reset_idle got=%b exp=%b", got, exp_out(P_STOP, 0));
        end
    endtask

    // One full burst from STOP back to STOP. req stays high for h cycles of HS_CLK
    // (cycle 0 = sot cycle); lane i pulses eot in HS_CLK cycle eot_t[i] (-1 = never).
    task automatic test_burst(input string name, input int lpx, input int prep, input int zero,
                              input int post, input int trail, input int ex,
                              input bit mode, input logic [NL-1:0] en, input int h);
        int         ph_a [3];
        int         ln_a [3];
        int         ph_b [3];
        int         ln_b [3];
        int         cx;
        logic [7:0] got;
        logic [7:0] want;
        logic [NL-1:0] e;
        ph_a = '{P_RQST, P_PREP, P_ZERO};
        ln_a = '{dur(lpx), dur(prep), dur(zero)};
        ph_b = '{P_POST, P_TRAIL, P_EXIT};
        ln_b = '{dur(post) - 1, dur(trail), dur(ex)};
        cx = h;
        if (!mode)
            for (int i = 0; i < int'(NL); i++)
                if (en[i] && eot_t[i] > cx) cx = eot_t[i];

        set_counts(lpx, prep, zero, post, trail, ex);
        lane_if.cont_clk_mode   = mode;
        lane_if.dlane_en        = en;
        lane_if.txrequesths_clk = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < ln_a[p]; k++) begin
                step();
                got = obs();
                n_tests++;
                if (got !== exp_out(ph_a[p], 0)) begin
                    n_fail++;
                    $display("FAIL %s entry ph%0d cyc%0d got=%b exp=%b", name, ph_a[p], k, got,
                             exp_out(ph_a[p], 0));
                end
            end
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_CLK, 1)) begin
            n_fail++;
            $display("FAIL %s sot got=%b exp=%b", name, got, exp_out(P_CLK, 1));
        end
        for (int c = 0; c <= cx; c++) begin
            e = '0;
            for (int i = 0; i < int'(NL); i++) if (eot_t[i] == c) e[i] = 1'b1;
            lane_if.eot             = e;
            lane_if.txrequesths_clk = (c < h);
            step();
            got  = obs();
            want = (c < cx) ? exp_out(P_CLK, 0) : exp_out(P_POST, 0);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s hs_clk cyc%0d got=%b exp=%b", name, c, got, want);
            end
        end
        lane_if.eot = '0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < ln_b[p]; k++) begin
                step();
                got = obs();
                n_tests++;
                if (got !== exp_out(ph_b[p], 0)) begin
                    n_fail++;
                    $display("FAIL %s exit ph%0d cyc%0d got=%b exp=%b", name, ph_b[p], k, got,
                             exp_out(ph_b[p], 0));
                end
            end
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_STOP, 0)) begin
            n_fail++;
            $display("FAIL %s back_to_stop got=%b exp=%b", name, got, exp_out(P_STOP, 0));
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < int'(NL); i++) eot_t[i] = -1;
        test_burst("t1_entry", 2, 3, 5, 1, 1, 1, 1'b1, 4'b0000, 1);
        eot_t = '{2, -1, 5, -1};
        test_burst("t2_eot_gate", 1, 1, 1, 1, 1, 1, 1'b0, 4'b0101, 1);
        for (int i = 0; i < int'(NL); i++) eot_t[i] = -1;
        test_burst("t3_cont_exit", 1, 1, 1, 4, 3, 6, 1'b1, 4'b1111, 2);
        test_burst("t5_zero_counts", 0, 0, 0, 0, 0, 0, 1'b0, 4'b0000, 1);
        eot_t = '{0, 0, 0, 0};
        test_burst("eot_in_sot_cycle", 1, 1, 1, 1, 1, 1, 1'b0, 4'b1111, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < int'(NL); i++) eot_t[i] = int'($urandom_range(0, 7));
            test_burst("random", int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), NL'($urandom_range(0, 15)),
                       int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_reset_mid_burst();
        int         seq [5];
        logic [7:0] got;
        seq = '{P_RQST, P_PREP, P_ZERO, P_CLK, P_CLK};
        set_counts(1, 1, 1, 1, 1, 1);
        lane_if.cont_clk_mode   = 1'b1;
        lane_if.txrequesths_clk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            got = obs();
            n_tests++;
            if (got !== exp_out(seq[k], k == 3)) begin
                n_fail++;
                $display("FAIL t4_lead_in cyc%0d got=%b exp=%b", k, got, exp_out(seq[k], k == 3));
            end
        end
        rst = 1'b1;
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_STOP, 0)) begin
            n_fail++;
            $display("FAIL t4_reset_in_hs got=%b exp=%b", got, exp_out(P_STOP, 0));
        end
        rst = 1'b0;
        lane_if.txrequesths_clk = 1'b0;
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_STOP, 0)) begin
            n_fail++;
            $display("FAIL t4_after_reset got=%b exp=%b", got, exp_out(P_STOP, 0));
        end
    endtask

    // Request re-raised in HS_POST must not abort; a pulse seen only in HS_EXIT is remembered.
    task automatic test_back_to_back();
        int         seq [16];
        bit         rq  [16];
        logic [7:0] got;
        seq = '{P_RQST, P_PREP, P_ZERO, P_CLK, P_POST, P_TRAIL, P_EXIT, P_STOP,
                P_RQST, P_PREP, P_ZERO, P_CLK, P_POST, P_TRAIL, P_EXIT, P_STOP};
        rq  = '{1, 1, 1, 0, 1, 1, 1, 0,
                0, 0, 0, 0, 0, 0, 1, 0};
        set_counts(1, 1, 1, 1, 1, 1);
        lane_if.cont_clk_mode   = 1'b1;
        lane_if.txrequesths_clk = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            got = obs();
            n_tests++;
            if (got !== exp_out(seq[k], k == 3 || k == 11)) begin
                n_fail++;
                $display("FAIL b2b cyc%0d got=%b exp=%b", k, got, exp_out(seq[k], k == 3 || k == 11));
            end
            lane_if.txrequesths_clk = rq[k];
        end
        step();
        got = obs();
        n_tests++;
        if (got !== exp_out(P_RQST, 0)) begin
            n_fail++;
            $display("FAIL b2b_held_req got=%b exp=%b", got, exp_out(P_RQST, 0));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef CSI2TX_DPHY_CLK_ULPS_EN
    task automatic test_ulps();
        int         seq [7];
        logic [7:0] got;
        seq = '{P_ULRQ, P_ULRQ, P_ULPS, P_ULPS, P_ULEX, P_ULEX, P_STOP};
        set_counts(2, 1, 1, 1, 1, 1);
        lane_if.txulpsclk = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            got = obs();
            n_tests++;
            if (got !== exp_out(seq[k], 0)) begin
                n_fail++;
                $display("FAIL t6_ulps cyc%0d got=%b exp=%b", k, got, exp_out(seq[k], 0));
            end
            if (k == 1) lane_if.txulpsclk = 1'b0;
            lane_if.txulpsexit_clk = (k == 3);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        lane_if.txrequesths_clk = 1'b0;
        lane_if.cont_clk_mode   = 1'b0;
        lane_if.dlane_en        = '0;
        lane_if.eot             = '0;
        lane_if.txulpsclk       = 1'b0;
        lane_if.txulpsexit_clk  = 1'b0;
        set_counts(1, 1, 1, 1, 1, 1);
        repeat (2) step();
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef CSI2TX_DPHY_CLK_ULPS_EN
        test_ulps();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
